load_store_unit: RTL
====================

# load_store_unit

Core-side load/store unit that drives the byte-enabled, synchronous-read data memory. Accepts one load or store request per transaction from the execute stage. Converts byte address, size and signedness into word address, byte-write mask and lane-shifted store data. On loads, realigns and sign- or zero-extends the registered read word. Misaligned accesses are split into two word accesses when enabled.

## Interface
- Parameters: none (memory is fixed at 4096 words; word index = addr[13:2]).
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request valid; sampled only while ready=1
- ready  out  1  1 only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- addr  in  32  byte address; addr[31:14] ignored
- wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  valid with rsp_valid; illegal funct3 or misaligned-not-supported
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 otherwise and for stores/errors
- mem_WE  out  4  byte write enables to memory
- mem_adr  out  12  memory word index
- mem_data_in  out  32  lane-aligned store data
- mem_ld  out  1  memory read strobe
- mem_str  out  1  memory write strobe
- mem_data_out  in  32  registered memory read data (0 when the previous cycle had ld=0)

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE: on req, latch we, funct3, addr, wdata. Go to ACC0 if legal. Go to RESP with err=1 if funct3 is illegal (011, 110, 111, or 100/101 with we=1). Go to RESP with err=1 if misaligned and split is disabled.
- Misaligned: H with off=addr[1:0]=3; W with off≠0. B is never misaligned.
- Byte mask: 8-bit m = base<<off, where base = 0001 (B), 0011 (H), 1111 (W). mask0=m[3:0], mask1=m[7:4]. Split iff mask1≠0.
- Store data: 64-bit s = {32'b0, wdata}<<(8·off). data0=s[31:0], data1=s[63:32].
- ACC0: mem_adr=addr[13:2], mem_WE=we?mask0:0, mem_str=we, mem_ld=~we, mem_data_in=data0. Go to ACC1 if split, else RESP.
- ACC1: mem_adr=addr[13:2]+1 (wraps 4095→0), mem_WE=we?mask1:0, mem_data_in=data1, same strobes. For loads, capture mem_data_out into lo register. Go to RESP.
- RESP: rsp_valid=1. Load word w = split ? {mem_data_out, lo} : {32'b0, mem_data_out}. r = w>>(8·off). Extend r[7:0] or r[15:0] by funct3[2] (1=zero, 0=sign); W passes r[31:0]. Return to IDLE.
- Outside ACC0/ACC1, all mem_* outputs are 0.
- Reset values: ready=1 (state IDLE); all other outputs 0; lo register = 0.

## Timing
- Requests are accepted on the clk edge where req&ready=1. ready falls the next cycle.
- Aligned/legal access: ACC0 is the cycle after accept; rsp_valid follows one cycle later (2 cycles after accept).
- Split access: rsp_valid is 3 cycles after accept.
- Error response: rsp_valid in the cycle after accept; no memory strobes.
- Repeat rate: next request accepted in the cycle after RESP, i.e. 3 cycles aligned, 4 cycles split.
- req while ready=0 is ignored; no queueing.
- Mid-operation reset (rst_n low): immediate return to IDLE. mem_* outputs go to 0 asynchronously. Any in-flight split store may leave only its first half written.

## Configuration
- MISALIGNED_SPLIT_EN defined: misaligned H/W accesses use the ACC0→ACC1 two-access split described above.
- Undefined: ACC1 is unreachable and the lo register is removed. Misaligned accesses complete as rsp_err=1 with no memory access.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, then LW 0x100 → mem_adr=0x040, mem_WE=1111; load rsp_rdata=0xDEADBEEF 2 cycles after accept.
- SB addr=0x203, wdata=0x80; then LB 0x203 → 0xFFFFFF80; LBU 0x203 → 0x00000080; mem_WE=1000 on the store.
- SH 0x10E, 0xA55A (aligned) then LHU 0x10E → 0x0000A55A. LH on a word holding 0x8001xxxx at off=2 → 0xFFFF8001.
- With MISALIGNED_SPLIT_EN: SW addr=0x3FFD (word 4095, off=1), wdata=0x11223344 → ACC0 WE=1110 adr=4095; ACC1 WE=0001 adr=0 (wrap). LW 0x3FFD → 0x11223344 after 3 cycles. Without the macro: rsp_err=1, no strobes.
- funct3=011 load, or funct3=100 with we=1 → rsp_err=1, rsp_rdata=0, mem_str=mem_ld=0 throughout.
- Assert rst_n low during ACC1 of a split store → mem_WE=0 immediately, ready=1 after release, only the first word modified.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit_if                                                 |
// | Request/response handshake toward the execute stage plus the       |
// | byte-enabled synchronous-read data memory port.                    |
// | master: core side and memory read return; slave: the LSU.          |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface load_store_unit_if;
  logic        req;
  logic        ready;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  mem_WE;
  logic [11:0] mem_adr;
  logic [31:0] mem_data_in;
  logic        mem_ld;
  logic        mem_str;
  logic [31:0] mem_data_out;

  modport master (
    output req, we, funct3, addr, wdata, mem_data_out,
    input  ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_WE, mem_adr, mem_data_in, mem_ld, mem_str
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_data_out,
    output ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_WE, mem_adr, mem_data_in, mem_ld, mem_str
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit                                                    |
// | Converts byte-addressed load/store requests into word accesses on  |
// | a byte-enabled synchronous-read memory; realigns and extends load  |
// | data. Optional macro MISALIGNED_SPLIT_EN enables splitting of      |
// | misaligned H/W accesses into two word accesses.                    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module load_store_unit (
  input  wire logic         clk,
  input  wire logic         rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [3:0]  r_mem_we;
  logic [11:0] r_mem_adr;
  logic [31:0] r_mem_din;
  logic        r_mem_ld;
  logic        r_mem_str;

  logic [3:0]  w_base;
  logic [7:0]  w_mask;
  logic [31:0] w_data0;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_reject;
  logic [31:0] w_r;
  logic [31:0] w_ext;
  logic        w_unused;

  // Upper address bits lie outside the 16 KiB memory and are ignored.
  assign w_unused = ^bus.addr[31:14];

  // Access footprint in byte lanes before shifting by the byte offset.
  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
  end

  // Lanes spilling into m[7:4] belong to the next word.
  assign w_mask       = {4'b0000, w_base} << bus.addr[1:0];
  assign w_misaligned = |w_mask[7:4];
  assign w_illegal    = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
                        (bus.funct3[2] && bus.we);

`ifdef MISALIGNED_SPLIT_EN
  logic        r_split;
  logic [11:0] r_adr;
  logic [3:0]  r_mask1;
  logic [31:0] r_data1;
  logic [31:0] r_lo;
  logic [63:0] w_s;
  logic [63:0] w_word;

  assign w_s      = {32'b0, bus.wdata} << {bus.addr[1:0], 3'b000};
  assign w_data0  = w_s[31:0];
  assign w_reject = w_illegal;
  // Low word was captured in ACC1; the high word arrives during RESP.
  assign w_word   = r_split ? {bus.mem_data_out, r_lo} : {32'b0, bus.mem_data_out};
  assign w_r      = 32'(w_word >> {r_off, 3'b000});
`else
  assign w_data0  = bus.wdata << {bus.addr[1:0], 3'b000};
  assign w_reject = w_illegal | w_misaligned;
  assign w_r      = bus.mem_data_out >> {r_off, 3'b000};
`endif

  // Size-dependent sign or zero extension of the realigned load word.
  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_ext = r_f3[2] ? {24'b0, w_r[7:0]}  : {{24{w_r[7]}}, w_r[7:0]};
      2'b01:   w_ext = r_f3[2] ? {16'b0, w_r[15:0]} : {{16{w_r[15]}}, w_r[15:0]};
      default: w_ext = w_r;
    endcase
  end

  // Control FSM; every memory and response output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_off       <= 2'b00;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 4'b0000;
      r_mem_adr   <= 12'd0;
      r_mem_din   <= 32'd0;
      r_mem_ld    <= 1'b0;
      r_mem_str   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      r_split     <= 1'b0;
      r_adr       <= 12'd0;
      r_mask1     <= 4'b0000;
      r_data1     <= 32'd0;
      r_lo        <= 32'd0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 4'b0000;
      r_mem_adr   <= 12'd0;
      r_mem_din   <= 32'd0;
      r_mem_ld    <= 1'b0;
      r_mem_str   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_f3    <= bus.funct3;
            r_off   <= bus.addr[1:0];
            r_ready <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            r_split <= w_misaligned;
            r_adr   <= bus.addr[13:2];
            r_mask1 <= w_mask[7:4];
            r_data1 <= w_s[63:32];
`endif
            if (w_reject) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state   <= ACC0;
              r_mem_adr <= bus.addr[13:2];
              r_mem_we  <= bus.we ? w_mask[3:0] : 4'b0000;
              r_mem_din <= w_data0;
              r_mem_ld  <= ~bus.we;
              r_mem_str <= bus.we;
            end
          end
        end
        ACC0: begin
`ifdef MISALIGNED_SPLIT_EN
          if (r_split) begin
            r_state   <= ACC1;
            r_mem_adr <= r_adr + 12'd1;
            r_mem_we  <= r_we ? r_mask1 : 4'b0000;
            r_mem_din <= r_data1;
            r_mem_ld  <= ~r_we;
            r_mem_str <= r_we;
          end else begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end
`else
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
`endif
        end
        ACC1: begin
`ifdef MISALIGNED_SPLIT_EN
          if (!r_we) r_lo <= bus.mem_data_out;
`endif
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_rdata   = (r_rsp_valid && !r_rsp_err && !r_we) ? w_ext : 32'd0;
  assign bus.mem_WE      = r_mem_we;
  assign bus.mem_adr     = r_mem_adr;
  assign bus.mem_data_in = r_mem_din;
  assign bus.mem_ld      = r_mem_ld;
  assign bus.mem_str     = r_mem_str;

endmodule
`default_nettype wire
